// File: rtl/box_painter_if.sv
// Pixel-request / colour-return bundle between the VGA timing stage and box_painter.
// Latency: none (wires only); draw_* and the pulses come back one clk after the coordinates.
// Backpressure: none; the timing stage streams coordinates every clk.
interface box_painter_if;
    logic        en;
    logic [1:0]  speed;
    logic [11:0] bg_rgb;
    logic [10:0] curr_x;
    logic [10:0] curr_y;
    logic [3:0]  draw_r;
    logic [3:0]  draw_g;
    logic [3:0]  draw_b;
    logic        frame_tick;
    logic        corner_hit;

    // Timing-stage side: drives coordinates and controls, receives colour.
    modport master (
        output en, speed, bg_rgb, curr_x, curr_y,
        input  draw_r, draw_g, draw_b, frame_tick, corner_hit
    );

    // Painter side.
    modport slave (
        input  en, speed, bg_rgb, curr_x, curr_y,
        output draw_r, draw_g, draw_b, frame_tick, corner_hit
    );
endinterface

// File: rtl/box_painter.sv
// Bouncing-square pixel source: draws a palette-coloured sprite over bg_rgb, moves it once per frame.
// Latency: 1 clk from curr_x/curr_y to draw_*; frame_tick/corner_hit 1 clk after the wrap edge.
// Backpressure: none; a new coordinate is accepted and a colour produced every clk.
module box_painter #(
    parameter int SCREEN_W = 1440,
    parameter int SCREEN_H = 900,
    parameter int BOX_SIZE = 64,
    parameter int STEP     = 2,
    parameter int INIT_X   = 0,
    parameter int INIT_Y   = 0
) (
    input  logic         clk,
    input  logic         rst,
    box_painter_if.slave bus
);
    localparam logic [11:0] L_BOX = 12'(BOX_SIZE);
    localparam logic [11:0] L_W   = 12'(SCREEN_W);
    localparam logic [11:0] L_H   = 12'(SCREEN_H);

    // Result of moving one axis by one step: new position, new direction, wall hit.
    typedef struct packed {
        logic        hit;
        logic        dir;   // 1 = moving toward larger coordinates
        logic [11:0] pos;
    } axis_t;

    // Advance one axis; a landing exactly on a wall clamps there, flips and counts as a hit.
    function automatic axis_t f_step_axis(input logic [11:0] pos, input logic dir,
                                          input logic [11:0] step, input logic [11:0] limit);
        axis_t r;
        r.hit = 1'b0;
        r.dir = dir;
        r.pos = pos;
        if (dir) begin
            if (pos + step + L_BOX >= limit) begin
                r.pos = limit - L_BOX;
                r.dir = 1'b0;
                r.hit = 1'b1;
            end else begin
                r.pos = pos + step;
            end
        end else begin
            if (pos <= step) begin
                r.pos = '0;
                r.dir = 1'b1;
                r.hit = 1'b1;
            end else begin
                r.pos = pos - step;
            end
        end
        return r;
    endfunction

    logic [11:0] r_box_x;
    logic [11:0] r_box_y;
    logic        r_dir_x;
    logic        r_dir_y;
    logic [2:0]  r_col_idx;
    logic [10:0] r_curr_y_d;
    logic [11:0] r_draw;
    logic        r_frame_tick;
    logic        r_corner_hit;

    logic [11:0] w_step;
    logic        w_wrap;
    axis_t       w_nx;
    axis_t       w_ny;
    logic        w_inside;
    logic [11:0] w_palette;

    assign w_step = 12'(STEP) * (12'(bus.speed) + 12'd1);
    // A frame wraps when the row drops to 0 from any non-zero row.
    assign w_wrap = (r_curr_y_d != 11'd0) && (bus.curr_y == 11'd0);
    assign w_nx   = f_step_axis(r_box_x, r_dir_x, w_step, L_W);
    assign w_ny   = f_step_axis(r_box_y, r_dir_y, w_step, L_H);

    // Coordinates outside the screen can never fall inside because the box is kept on-screen.
    assign w_inside = ({1'b0, bus.curr_x} >= r_box_x) && ({1'b0, bus.curr_x} < r_box_x + L_BOX) &&
                      ({1'b0, bus.curr_y} >= r_box_y) && ({1'b0, bus.curr_y} < r_box_y + L_BOX);

    // Sprite palette lookup.
    always_comb begin
        w_palette = 12'hFFF;
        case (r_col_idx)
            3'd0: w_palette = 12'hFFF;
            3'd1: w_palette = 12'hF00;
            3'd2: w_palette = 12'h0F0;
            3'd3: w_palette = 12'h00F;
            3'd4: w_palette = 12'hFF0;
            3'd5: w_palette = 12'h0FF;
            3'd6: w_palette = 12'hF0F;
            3'd7: w_palette = 12'hF80;
            default: w_palette = 12'hFFF;
        endcase
    end

    // Sprite state only moves on the wrap edge, so a frame is never drawn half-old, half-new.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_box_x   <= 12'(INIT_X);
            r_box_y   <= 12'(INIT_Y);
            r_dir_x   <= 1'b1;
            r_dir_y   <= 1'b1;
            r_col_idx <= 3'd0;
        end else if (w_wrap && bus.en) begin
            r_box_x <= w_nx.pos;
            r_box_y <= w_ny.pos;
            r_dir_x <= w_nx.dir;
            r_dir_y <= w_ny.dir;
            // A corner bounce still advances the colour by one, not two.
            if (w_nx.hit || w_ny.hit) begin
                r_col_idx <= r_col_idx + 3'd1;
            end
        end
    end

    // Row history for wrap detection and the per-frame pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_curr_y_d   <= 11'd0;
            r_frame_tick <= 1'b0;
            r_corner_hit <= 1'b0;
        end else begin
            r_curr_y_d   <= bus.curr_y;
            r_frame_tick <= w_wrap;
            r_corner_hit <= w_wrap && bus.en && w_nx.hit && w_ny.hit;
        end
    end

    // Registered colour output; blanking is applied downstream.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_draw <= 12'h000;
        end else begin
            r_draw <= w_inside ? w_palette : bus.bg_rgb;
        end
    end

    assign bus.draw_r     = r_draw[11:8];
    assign bus.draw_g     = r_draw[7:4];
    assign bus.draw_b     = r_draw[3:0];
    assign bus.frame_tick = r_frame_tick;
    assign bus.corner_hit = r_corner_hit;
endmodule

// File: tb/tb_box_painter.sv
// Directed bench for box_painter: three instances with different start positions share stimulus.
// Pixel probes come from a table; wraps, freeze and resets are hand-written sequences.
module tb_box_painter;
    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  speed;
    logic [11:0] bg_rgb;
    logic [10:0] curr_x;
    logic [10:0] curr_y;

    int checks;
    int failures;

    box_painter_if if0 ();
    box_painter_if if1 ();
    box_painter_if if2 ();

    assign if0.en = en;  assign if0.speed = speed;  assign if0.bg_rgb = bg_rgb;
    assign if0.curr_x = curr_x;  assign if0.curr_y = curr_y;
    assign if1.en = en;  assign if1.speed = speed;  assign if1.bg_rgb = bg_rgb;
    assign if1.curr_x = curr_x;  assign if1.curr_y = curr_y;
    assign if2.en = en;  assign if2.speed = speed;  assign if2.bg_rgb = bg_rgb;
    assign if2.curr_x = curr_x;  assign if2.curr_y = curr_y;

    box_painter dut0 (.clk(clk), .rst(rst), .bus(if0));
    box_painter #(.INIT_X(1375), .INIT_Y(400)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    box_painter #(.INIT_X(1375), .INIT_Y(835)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          phase;
        int          dut;
        logic [10:0] x;
        logic [10:0] y;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int p, input int d, input int x, input int y, input logic [11:0] e);
        vec_t v;
        v.phase = p; v.dut = d; v.x = 11'(x); v.y = 11'(y); v.exp = e;
        vecs.push_back(v);
    endfunction

    function automatic logic [11:0] get_rgb(input int d);
        case (d)
            0: return {if0.draw_r, if0.draw_g, if0.draw_b};
            1: return {if1.draw_r, if1.draw_g, if1.draw_b};
            default: return {if2.draw_r, if2.draw_g, if2.draw_b};
        endcase
    endfunction

    function automatic logic get_tick(input int d);
        case (d)
            0: return if0.frame_tick;
            1: return if1.frame_tick;
            default: return if2.frame_tick;
        endcase
    endfunction

    function automatic logic get_corner(input int d);
        case (d)
            0: return if0.corner_hit;
            1: return if1.corner_hit;
            default: return if2.corner_hit;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply every table vector of one phase, one pixel per clk, checking one clk later.
    task automatic run_phase(input int p);
        foreach (vecs[i]) begin
            if (vecs[i].phase == p) begin
                curr_x = vecs[i].x;
                curr_y = vecs[i].y;
                tick();
                chk($sformatf("pix p%0d dut%0d (%0d,%0d)", p, vecs[i].dut, vecs[i].x, vecs[i].y),
                    32'(get_rgb(vecs[i].dut)), 32'(vecs[i].exp));
            end
        end
    endtask

    // Row 5 -> 0 produces one wrap; pulses are checked over the three cycles that follow.
    task automatic do_wrap(input logic c0, input logic c1, input logic c2, output int ticks0);
        logic [2:0] exp_c;
        exp_c = {c2, c1, c0};
        curr_x = 11'd700;
        curr_y = 11'd5;
        tick();
        curr_y = 11'd0;
        tick();
        ticks0 = 0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("frame_tick dut%0d", d), 32'(get_tick(d)), 32'd1);
            chk($sformatf("corner_hit dut%0d", d), 32'(get_corner(d)), 32'(exp_c[d]));
        end
        if (if0.frame_tick) ticks0++;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (if0.frame_tick) ticks0++;
            chk($sformatf("corner_hit low after dut2 c%0d", c), 32'(if2.corner_hit), 32'd0);
        end
        chk("frame_tick single pulse dut0", 32'(ticks0), 32'd1);
    endtask

    initial begin
        int t;
        int freeze_ticks;
        checks = 0;
        failures = 0;

        add(1, 0, 10, 10, 12'hFFF);     add(1, 0, 100, 10, 12'h123);
        add(1, 1, 1375, 400, 12'hFFF);  add(1, 1, 1374, 400, 12'h123);
        add(1, 2, 1375, 835, 12'hFFF);  add(1, 2, 1438, 898, 12'hFFF);
        add(1, 2, 1439, 899, 12'h123);

        add(2, 0, 65, 65, 12'hFFF);     add(2, 0, 1, 2, 12'h123);
        add(2, 0, 2, 1, 12'h123);
        add(2, 1, 1376, 402, 12'hF00);  add(2, 1, 1375, 402, 12'h123);
        add(2, 1, 1439, 465, 12'hF00);
        add(2, 2, 1376, 836, 12'hF00);  add(2, 2, 1376, 835, 12'h123);
        add(2, 2, 1439, 899, 12'hF00);

        add(3, 0, 4, 4, 12'hFFF);       add(3, 0, 3, 4, 12'h123);
        add(3, 1, 1374, 404, 12'hF00);  add(3, 1, 1438, 404, 12'h123);
        add(3, 1, 1373, 404, 12'h123);
        add(3, 2, 1374, 834, 12'hF00);  add(3, 2, 1374, 898, 12'h123);

        add(5, 0, 8, 8, 12'hFFF);       add(5, 0, 7, 8, 12'h123);
        add(5, 0, 71, 71, 12'hFFF);     add(5, 0, 72, 71, 12'h123);
        add(5, 1, 1376, 408, 12'hF00);  add(5, 1, 1376, 407, 12'h123);
        add(5, 2, 1376, 836, 12'hF00);

        add(6, 1, 1375, 400, 12'hFFF);  add(6, 1, 1374, 400, 12'h123);
        add(6, 2, 1375, 835, 12'hFFF);
        add(6, 0, 0, 1, 12'hFFF);       add(6, 0, 64, 1, 12'h123);

        // Reset and idle draw.
        rst = 1'b0; en = 1'b0; speed = 2'd0; bg_rgb = 12'h123;
        curr_x = 11'd10; curr_y = 11'd10;
        repeat (4) tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset rgb dut%0d", d), 32'(get_rgb(d)), 32'd0);
            chk($sformatf("reset tick dut%0d", d), 32'(get_tick(d)), 32'd0);
            chk($sformatf("reset corner dut%0d", d), 32'(get_corner(d)), 32'd0);
        end
        rst = 1'b1;
        run_phase(1);

        // First wrap: dut0 moves to (2,2); dut1 bounces off the right wall; dut2 hits the corner.
        en = 1'b1;
        do_wrap(1'b0, 1'b0, 1'b1, t);
        run_phase(2);

        // Second wrap: bounced axes now move back.
        do_wrap(1'b0, 1'b0, 1'b0, t);
        run_phase(3);

        // Freeze: three wraps, sprites and colours stay put, ticks still pulse.
        en = 1'b0;
        freeze_ticks = 0;
        repeat (3) begin
            do_wrap(1'b0, 1'b0, 1'b0, t);
            freeze_ticks += t;
        end
        chk("freeze tick count", 32'(freeze_ticks), 32'd3);
        run_phase(3);

        // Restart from reset position with the largest step.
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        en = 1'b1;
        speed = 2'd3;
        do_wrap(1'b0, 1'b0, 1'b1, t);
        run_phase(5);

        // Reset landing on a wrap edge wins over the position update.
        curr_y = 11'd5;
        tick();
        curr_y = 11'd0;
        rst = 1'b0;
        tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("wrap-reset tick dut%0d", d), 32'(get_tick(d)), 32'd0);
            chk($sformatf("wrap-reset corner dut%0d", d), 32'(get_corner(d)), 32'd0);
        end
        chk("wrap-reset rgb dut1", 32'(get_rgb(1)), 32'd0);
        rst = 1'b1;
        tick();
        chk("no tick after reset release", 32'(if0.frame_tick), 32'd0);
        run_phase(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/box_painter.md
Name: box_painter

Overview:
- Pixel-colour source for the VGA timing stage: consumes curr_x/curr_y and returns draw_r/g/b for the 1440x900 active area.
- Renders a solid square sprite over a switch-selected background. The sprite bounces off the screen edges, moves once per frame, and changes colour on every wall hit.
- Colour output is registered. Sprite position is updated only at frame wrap, so no tearing occurs.

Parameters:
- SCREEN_W, 1440, active width in pixels.
- SCREEN_H, 900, active height in lines.
- BOX_SIZE, 64, sprite edge length in pixels.
- STEP, 2, base movement per frame, in pixels.
- INIT_X, 0, sprite left edge after reset.
- INIT_Y, 0, sprite top edge after reset.

Ports:
- clk  in  1  pixel clock, same clock as the timing stage.
- rst  in  1  synchronous, active-low reset.
- en  in  1  motion enable; 0 freezes the sprite (it is still drawn).
- speed  in  2  step multiplier; step = STEP*(speed+1).
- bg_rgb  in  12  background colour {r,g,b}, 4 bits each.
- curr_x  in  11  active-area column from the timing stage.
- curr_y  in  11  active-area row from the timing stage.
- draw_r  out  4  pixel red.
- draw_g  out  4  pixel green.
- draw_b  out  4  pixel blue.
- frame_tick  out  1  one-cycle pulse, asserted the cycle after a position update point.
- corner_hit  out  1  one-cycle pulse, coincident with frame_tick, when both axes bounced in the same update.

Behaviour:
- Reset (rst==0 at a clk edge) sets:
  - box_x=INIT_X, box_y=INIT_Y.
  - dir_x=+ (right), dir_y=+ (down).
  - col_idx=0.
  - curr_y_d=0.
  - draw_r/g/b=0, frame_tick=0, corner_hit=0.
- Reset has priority over every other event, including a reset asserted mid-frame or on a tick cycle.
- Frame wrap detection:
  - curr_y_d registers curr_y every cycle.
  - wrap = (curr_y_d != 0) && (curr_y == 0).
- Position update on the edge where wrap==1:
  - If en==1, each axis updates independently.
  - Moving +: if pos + step + BOX_SIZE >= limit, then pos = limit - BOX_SIZE, direction flips, and that axis counts as hit. Otherwise pos += step.
  - Moving -: if pos <= step, then pos = 0, direction flips, and that axis counts as hit. Otherwise pos -= step.
  - limit is SCREEN_W for x and SCREEN_H for y.
  - If en==0, position, direction and colour are held.
- Colour index on the update edge:
  - Either axis hit: col_idx = col_idx + 1, mod 8.
  - Both axes hit: col_idx still increments by exactly 1, and corner_hit is raised.
- frame_tick and corner_hit:
  - frame_tick is registered from wrap and is high for exactly 1 cycle after every wrap, regardless of en.
  - corner_hit is high only in that same cycle.
- Arithmetic:
  - All position math is 12-bit unsigned, so it cannot overflow.
  - step is at most 4*STEP.
  - A landing position exactly on the wall counts as a hit.
- Palette, indexed by col_idx:
  - 0 FFF, 1 F00, 2 0F0, 3 00F, 4 FF0, 5 0FF, 6 F0F, 7 F80.
- Drawing:
  - inside = (curr_x >= box_x) && (curr_x < box_x+BOX_SIZE) && (curr_y >= box_y) && (curr_y < box_y+BOX_SIZE).
  - Registered output: {draw_r,draw_g,draw_b} <= inside ? palette[col_idx] : bg_rgb.
  - Latency is 1 clk from curr_x/curr_y to draw_*.
  - Blanking masking is done downstream; this block does not mask.
- Coordinate inputs outside 0..SCREEN_W-1 / 0..SCREEN_H-1 are not inside the box and output bg_rgb.
- No state changes other than the registered draw path occur within a frame.

Test Plan:
1. Reset and idle draw:
   - Stimulus: rst=0 for 4 clks, then release; bg_rgb=12'h123; drive curr_x=10, curr_y=10.
   - Required: draw_* = F,F,F one clk later. With curr_x=100, draw_* = 1,2,3. During reset, all outputs are 0.
2. Frame motion:
   - Stimulus: en=1, speed=0; drive curr_y 5 -> 0.
   - Required: box moves to (2,2); frame_tick high for exactly 1 cycle; the pixel at (65,65) is now inside the box.
3. Right-wall bounce:
   - Stimulus: preload via INIT_X=1375, INIT_Y=400; speed=0; one wrap.
   - Required: box_x=1376, dir_x=-, col_idx=1, draw=F00 inside the box, corner_hit=0.
   - Next wrap: box_x=1374.
4. Corner hit:
   - Stimulus: INIT_X=1375, INIT_Y=835; one wrap.
   - Required: box at (1376,836), both directions flip, col_idx=1 (not 2), corner_hit=1 coincident with frame_tick.
5. Freeze and speed:
   - Stimulus: en=0, 3 wraps.
   - Required: position and colour unchanged; frame_tick pulses 3 times.
   - Then en=1, speed=3 from (0,0): next wrap gives (8,8).
6. Mid-frame reset:
   - Stimulus: assert rst on the same edge as a wrap.
   - Required: box=(INIT_X,INIT_Y), col_idx=0, frame_tick=0 on the following cycle.
